// File: rtl/timer_pkg.sv
// Shared types, constants and BCD helpers for the countdown timer subsystem.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_RINGING = 2'd3
    } timer_state_e;

    localparam int unsigned MAX_H      = 99;
    localparam int unsigned RING_TICKS = 5;
    localparam int unsigned SAND_MAX   = 15;
    localparam int unsigned ADD_5_MIN  = 5;
    localparam int unsigned ADD_10_MIN = 10;
    localparam int unsigned ADD_15_MIN = 15;
    localparam int unsigned SEC_W      = 19;
    localparam int unsigned DIVD_W     = 23;
    localparam int unsigned BTN_W      = 8;

    typedef struct packed {
        logic [3:0] h_t;
        logic [3:0] h_o;
        logic [3:0] m_t;
        logic [3:0] m_o;
        logic [3:0] s_t;
        logic [3:0] s_o;
    } bcd_time_t;

    function automatic logic [SEC_W-1:0] bcd_to_secs(input bcd_time_t t);
        return SEC_W'(t.h_t) * SEC_W'(36000) + SEC_W'(t.h_o) * SEC_W'(3600)
             + SEC_W'(t.m_t) * SEC_W'(600)   + SEC_W'(t.m_o) * SEC_W'(60)
             + SEC_W'(t.s_t) * SEC_W'(10)    + SEC_W'(t.s_o);
    endfunction

    // One digit of a borrow chain: wraps to 'top' when it borrows.
    function automatic logic [3:0] dig_dec(input logic [3:0] d, input logic [3:0] top,
                                           input logic en, output logic bout);
        bout = en && (d == 4'd0);
        if (!en) return d;
        return (d == 4'd0) ? top : d - 4'd1;
    endfunction

    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        logic b0, b1, b2, b3, b4;
        r     = t;
        r.s_o = dig_dec(t.s_o, 4'd9, 1'b1, b0);
        r.s_t = dig_dec(t.s_t, 4'd5, b0, b1);
        r.m_o = dig_dec(t.m_o, 4'd9, b1, b2);
        r.m_t = dig_dec(t.m_t, 4'd5, b2, b3);
        r.h_o = dig_dec(t.h_o, 4'd9, b3, b4);
        r.h_t = dig_dec(t.h_t, 4'd9, b4, b0);
        return r;
    endfunction

    // Two-digit field increment that wraps to 00 past {tens_top, 9}.
    function automatic logic [7:0] inc_pair(input logic [3:0] tens, input logic [3:0] ones,
                                            input logic [3:0] tens_top);
        if (ones != 4'd9) return {tens, ones + 4'd1};
        return {(tens == tens_top) ? 4'd0 : tens + 4'd1, 4'd0};
    endfunction

    // Adds n minutes with carry into hours; returns 0 if the result passes 99:59:59.
    function automatic logic add_minutes(input bcd_time_t t, input logic [3:0] n,
                                         output bcd_time_t r);
        logic [6:0] m_bin;
        logic [6:0] h_bin;
        m_bin = 7'(t.m_t) * 7'd10 + 7'(t.m_o) + 7'(n);
        h_bin = 7'(t.h_t) * 7'd10 + 7'(t.h_o);
        if (m_bin >= 7'd60) begin
            m_bin = m_bin - 7'd60;
            h_bin = h_bin + 7'd1;
        end
        r     = t;
        r.m_t = 4'(m_bin / 7'd10);
        r.m_o = 4'(m_bin % 7'd10);
        r.h_t = 4'(h_bin / 7'd10);
        r.h_o = 4'(h_bin % 7'd10);
        return h_bin <= 7'(MAX_H);
    endfunction

endpackage

// File: rtl/sand_divider.sv
// Four-step restoring divider producing floor(remaining*15/total) for the hourglass level.
module sand_divider
    import timer_pkg::*;
(
    input  logic             clk_1k,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEC_W-1:0] remaining,
    input  logic [SEC_W-1:0] total,
    output logic             done,
    output logic [3:0]       quot
);

    logic [DIVD_W-1:0] acc, acc_n, shifted;
    logic [SEC_W-1:0]  divisor, divisor_n;
    logic [1:0]        step, step_n;
    logic              busy, busy_n, done_n;
    logic [3:0]        quot_n;

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            divisor <= '0;
            step    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
        end else begin
            acc     <= acc_n;
            divisor <= divisor_n;
            step    <= step_n;
            busy    <= busy_n;
            done    <= done_n;
            quot    <= quot_n;
        end
    end

    // A new start always restarts the division, discarding any one in flight.
    always_comb begin
        acc_n     = acc;
        divisor_n = divisor;
        step_n    = step;
        busy_n    = busy;
        done_n    = 1'b0;
        quot_n    = quot;
        shifted   = DIVD_W'(divisor) << step;
        if (start) begin
            acc_n     = DIVD_W'({remaining, 4'b0000}) - DIVD_W'(remaining);
            divisor_n = total;
            step_n    = 2'd3;
            busy_n    = 1'b1;
            quot_n    = '0;
        end else if (busy) begin
            if (acc >= shifted) begin
                acc_n        = acc - shifted;
                quot_n[step] = 1'b1;
            end
            if (step == 2'd0) begin
                busy_n = 1'b0;
                done_n = 1'b1;
            end else begin
                step_n = step - 2'd1;
            end
        end
    end

endmodule

// File: rtl/timer_controller.sv
// Countdown timer: button handling, HH:MM:SS BCD countdown, alarm and indicator outputs.
module timer_controller
    import timer_pkg::*;
(
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       timer_sw,
    input  logic       btn_h_inc,
    input  logic       btn_m_inc,
    input  logic       btn_s_inc,
    input  logic       btn_confirm,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_add5,
    input  logic       btn_add10,
    input  logic       btn_add15,
    output logic [3:0] tm_h_tens,
    output logic [3:0] tm_h_ones,
    output logic [3:0] tm_m_tens,
    output logic [3:0] tm_m_ones,
    output logic [3:0] tm_s_tens,
    output logic [3:0] tm_s_ones,
    output logic [1:0] timer_state,
    output logic       led_1_blink,
    output logic [2:0] rgb_pwm,
    output logic       piezo_out,
    output logic [3:0] sand_count
);

    timer_state_e     state, state_n;
    bcd_time_t        tm, tm_n, tm_dec, tm_add;
    logic [SEC_W-1:0] remaining, rem_n, total, tot_n, add_secs;
    logic [2:0]       ring_cnt, ring_n;
    logic [7:0]       cyc, cyc_n;
    logic [BTN_W-1:0] btn_vec, btn_prev, press;
    logic [3:0]       add_amt, sand_n, div_quot;
    logic [2:0]       rgb_n;
    logic             led_n, piezo_n, div_start, div_start_n, div_done, add_ok, pwm_on;

    assign btn_vec = {btn_add15, btn_add10, btn_add5, btn_start,
                      btn_confirm, btn_s_inc, btn_m_inc, btn_h_inc};
    assign press   = btn_vec & ~btn_prev & {BTN_W{timer_sw}};

    assign tm_h_tens   = tm.h_t;
    assign tm_h_ones   = tm.h_o;
    assign tm_m_tens   = tm.m_t;
    assign tm_m_ones   = tm.m_o;
    assign tm_s_tens   = tm.s_t;
    assign tm_s_ones   = tm.s_o;
    assign timer_state = state;

    sand_divider u_sand_divider (
        .clk_1k    (clk_1k),
        .rst_n     (rst_n),
        .start     (div_start),
        .remaining (remaining),
        .total     (total),
        .done      (div_done),
        .quot      (div_quot)
    );

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tm          <= '0;
            remaining   <= '0;
            total       <= '0;
            ring_cnt    <= '0;
            cyc         <= '0;
            btn_prev    <= '0;
            div_start   <= 1'b0;
            led_1_blink <= 1'b0;
            piezo_out   <= 1'b0;
            rgb_pwm     <= '0;
            sand_count  <= '0;
        end else begin
            state       <= state_n;
            tm          <= tm_n;
            remaining   <= rem_n;
            total       <= tot_n;
            ring_cnt    <= ring_n;
            cyc         <= cyc_n;
            btn_prev    <= btn_vec;
            div_start   <= div_start_n;
            led_1_blink <= led_n;
            piezo_out   <= piezo_n;
            rgb_pwm     <= rgb_n;
            sand_count  <= sand_n;
        end
    end

    // Events resolve in priority order: clear, confirm, start, tick, add, increment.
    always_comb begin
        state_n     = state;
        tm_n        = tm;
        rem_n       = remaining;
        tot_n       = total;
        ring_n      = ring_cnt;
        cyc_n       = cyc + 8'd1;
        div_start_n = 1'b0;
        tm_dec      = bcd_dec(tm);
        add_amt     = press[7] ? 4'(ADD_15_MIN) :
                      press[6] ? 4'(ADD_10_MIN) :
                      press[5] ? 4'(ADD_5_MIN)  : 4'd0;
        add_secs    = SEC_W'(add_amt) * SEC_W'(60);
        add_ok      = add_minutes(tm, add_amt, tm_add);

        if (btn_clear) begin
            state_n = ST_IDLE;
            tm_n    = '0;
            rem_n   = '0;
            tot_n   = '0;
            ring_n  = '0;
            cyc_n   = '0;
        end else if (press[3] && state == ST_RINGING) begin
            state_n = ST_IDLE;
            ring_n  = '0;
            rem_n   = '0;
            tot_n   = '0;
        end else if (press[4] && (state == ST_RUNNING || state == ST_PAUSED ||
                                  (state == ST_IDLE && tm != '0))) begin
            if (state == ST_IDLE) begin
                state_n     = ST_RUNNING;
                rem_n       = bcd_to_secs(tm);
                tot_n       = bcd_to_secs(tm);
                div_start_n = 1'b1;
            end else begin
                state_n = (state == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
            end
        end else if (tick_1hz && state == ST_RUNNING) begin
            tm_n        = tm_dec;
            rem_n       = remaining - SEC_W'(1);
            div_start_n = 1'b1;
            if (tm_dec == '0) begin
                state_n = ST_RINGING;
                ring_n  = '0;
            end
        end else if (tick_1hz && state == ST_RINGING) begin
            if (ring_cnt == 3'(RING_TICKS - 1)) begin
                state_n = ST_IDLE;
                ring_n  = '0;
                rem_n   = '0;
                tot_n   = '0;
            end else begin
                ring_n = ring_cnt + 3'd1;
            end
        end else if (add_amt != 4'd0 && state != ST_RINGING) begin
            if (add_ok) begin
                tm_n = tm_add;
                if (state != ST_IDLE) begin
                    rem_n       = remaining + add_secs;
                    tot_n       = total + add_secs;
                    div_start_n = 1'b1;
                end
            end
        end else if (state == ST_IDLE) begin
            if (press[0]) {tm_n.h_t, tm_n.h_o} = inc_pair(tm.h_t, tm.h_o, 4'd9);
            if (press[1]) {tm_n.m_t, tm_n.m_o} = inc_pair(tm.m_t, tm.m_o, 4'd5);
            if (press[2]) {tm_n.s_t, tm_n.s_o} = inc_pair(tm.s_t, tm.s_o, 4'd5);
        end

        piezo_n = (state_n == ST_RINGING) ? ~piezo_out : 1'b0;
        case (state_n)
            ST_IDLE:    led_n = 1'b0;
            ST_RUNNING: led_n = (tick_1hz && state == ST_RUNNING) ? ~led_1_blink : led_1_blink;
            ST_PAUSED:  led_n = led_1_blink;
            default:    led_n = cyc_n[7];
        endcase

        case (state_n)
            ST_IDLE:    sand_n = (tm_n != '0) ? 4'(SAND_MAX) : 4'd0;
            ST_RINGING: sand_n = 4'd0;
            default:    sand_n = div_done ? div_quot : sand_count;
        endcase

        pwm_on = cyc_n[2];
        case (state_n)
            ST_IDLE:    rgb_n = 3'b000;
            ST_RINGING: rgb_n = {pwm_on & led_n, 2'b00};
            default: begin
                if (sand_n >= 4'd8)      rgb_n = {1'b0, pwm_on, 1'b0};
                else if (sand_n >= 4'd4) rgb_n = {pwm_on, pwm_on, 1'b0};
                else                     rgb_n = {pwm_on, 2'b00};
            end
        endcase
    end

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with a seconds-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_timer_controller;

    localparam int B_H = 0, B_M = 1, B_S = 2, B_CONF = 3, B_START = 4;
    localparam int B_A5 = 5, B_A10 = 6, B_A15 = 7;

    logic       clk_1k = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       timer_sw = 1'b0;
    logic       btn_clear = 1'b0;
    logic [7:0] btn = '0;
    logic [3:0] tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones;
    logic [1:0] timer_state;
    logic       led_1_blink, piezo_out;
    logic [2:0] rgb_pwm;
    logic [3:0] sand_count;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk_1k = ~clk_1k;

    timer_controller dut (
        .clk_1k      (clk_1k),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .timer_sw    (timer_sw),
        .btn_h_inc   (btn[B_H]),
        .btn_m_inc   (btn[B_M]),
        .btn_s_inc   (btn[B_S]),
        .btn_confirm (btn[B_CONF]),
        .btn_start   (btn[B_START]),
        .btn_clear   (btn_clear),
        .btn_add5    (btn[B_A5]),
        .btn_add10   (btn[B_A10]),
        .btn_add15   (btn[B_A15]),
        .tm_h_tens   (tm_h_tens),
        .tm_h_ones   (tm_h_ones),
        .tm_m_tens   (tm_m_tens),
        .tm_m_ones   (tm_m_ones),
        .tm_s_tens   (tm_s_tens),
        .tm_s_ones   (tm_s_ones),
        .timer_state (timer_state),
        .led_1_blink (led_1_blink),
        .rgb_pwm     (rgb_pwm),
        .piezo_out   (piezo_out),
        .sand_count  (sand_count)
    );

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    function automatic int dut_hhmmss();
        return (int'(tm_h_tens) * 10 + int'(tm_h_ones)) * 10000
             + (int'(tm_m_tens) * 10 + int'(tm_m_ones)) * 100
             +  int'(tm_s_tens) * 10 + int'(tm_s_ones);
    endfunction

    // Reference model: time kept as plain seconds, state as an integer code.
    int         m_h, m_m, m_s, m_st, m_rem, m_tot, m_ring, m_cyc, m_settle;
    bit         m_led, m_piezo;
    logic [7:0] m_prev;

    function automatic int exp_sand();
        if (m_st == 0) return (m_h + m_m + m_s != 0) ? 15 : 0;
        if (m_st == 3) return 0;
        return m_rem * 15 / m_tot;
    endfunction

    function automatic int exp_rgb();
        int on;
        int sd;
        on = (m_cyc >> 2) & 1;
        sd = exp_sand();
        if (m_st == 0) return 0;
        if (m_st == 3) return (on != 0 && m_led) ? 4 : 0;
        if (sd >= 8) return on * 2;
        if (sd >= 4) return on * 6;
        return on * 4;
    endfunction

    always @(posedge clk_1k or negedge rst_n) begin : model
        logic [7:0] pr;
        int secs, old_secs, old_st, old_rem, old_tot, n, h, mm, s;
        bit ticked;
        if (!rst_n) begin
            m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_rem = 0; m_tot = 0;
            m_ring = 0; m_cyc = 0; m_settle = 0; m_led = 0; m_piezo = 0; m_prev = '0;
        end else begin
            pr       = btn & ~m_prev & {8{timer_sw}};
            m_prev   = btn;
            secs     = m_h * 3600 + m_m * 60 + m_s;
            old_secs = secs; old_st = m_st; old_rem = m_rem; old_tot = m_tot;
            ticked   = 0;
            m_cyc    = (m_cyc + 1) % 256;
            if (btn_clear) begin
                secs = 0; m_st = 0; m_rem = 0; m_tot = 0; m_ring = 0; m_cyc = 0;
            end else if (pr[B_CONF] && m_st == 3) begin
                m_st = 0; m_ring = 0; m_rem = 0; m_tot = 0;
            end else if (pr[B_START] && (m_st == 1 || m_st == 2 || (m_st == 0 && secs != 0))) begin
                if (m_st == 0) begin
                    m_st = 1; m_rem = secs; m_tot = secs;
                end else begin
                    m_st = 3 - m_st;
                end
            end else if (tick_1hz && m_st == 1) begin
                secs--; m_rem--; ticked = 1;
                if (secs == 0) begin
                    m_st = 3; m_ring = 0;
                end
            end else if (tick_1hz && m_st == 3) begin
                m_ring++;
                if (m_ring == 5) begin
                    m_st = 0; m_ring = 0; m_rem = 0; m_tot = 0;
                end
            end else if (pr[7:5] != 0 && m_st != 3) begin
                n = pr[B_A15] ? 15 : (pr[B_A10] ? 10 : 5);
                if (secs + n * 60 <= 359999) begin
                    secs += n * 60;
                    if (m_st != 0) begin
                        m_rem += n * 60; m_tot += n * 60;
                    end
                end
            end else if (m_st == 0) begin
                h = secs / 3600; mm = (secs / 60) % 60; s = secs % 60;
                if (pr[B_H]) h = (h + 1) % 100;
                if (pr[B_M]) mm = (mm + 1) % 60;
                if (pr[B_S]) s = (s + 1) % 60;
                secs = h * 3600 + mm * 60 + s;
            end
            m_h = secs / 3600; m_m = (secs / 60) % 60; m_s = secs % 60;
            case (m_st)
                0: m_led = 0;
                1: if (ticked) m_led = ~m_led;
                2: ;
                default: m_led = ((m_cyc >> 7) & 1) != 0;
            endcase
            m_piezo = (m_st == 3) ? ~m_piezo : 1'b0;
            if (secs != old_secs || m_st != old_st || m_rem != old_rem || m_tot != old_tot)
                m_settle = 0;
            else if (m_settle < 100)
                m_settle++;
        end
    end

    // Per-cycle comparison; hourglass and colour only once the divider has had time to settle.
    always @(posedge clk_1k) begin
        #1;
        chk("state", int'(timer_state), m_st);
        chk("time", dut_hhmmss(), m_h * 10000 + m_m * 100 + m_s);
        chk("led", int'(led_1_blink), int'(m_led));
        chk("piezo", int'(piezo_out), int'(m_piezo));
        if (m_settle >= 8) begin
            chk("sand", int'(sand_count), exp_sand());
            chk("rgb", int'(rgb_pwm), exp_rgb());
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_1k);
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1; step(1);
        btn[b] = 1'b0; step(1);
    endtask

    task automatic presses(input int b, input int n);
        repeat (n) press(b);
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1; step(1);
        tick_1hz = 1'b0; step(11);
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic do_clear();
        btn_clear = 1'b1; step(1);
        btn_clear = 1'b0; step(1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_state"}, int'(timer_state), 0);
        chk({nm, "_time"}, dut_hhmmss(), 0);
        chk({nm, "_outs"}, int'({led_1_blink, piezo_out, rgb_pwm, sand_count}), 0);
    endtask

    initial begin
        step(3);
        chk_all_zero("lit_reset");
        rst_n = 1'b1;
        step(2);

        // 5 s countdown into ringing, then 5 ringing ticks back to idle
        timer_sw = 1'b1;
        do_clear();
        presses(B_S, 5);
        chk("lit_set5", dut_hhmmss(), 5);
        step(8);
        chk("lit_sand_idle", int'(sand_count), 15);
        press(B_START);
        chk("lit_run", int'(timer_state), 1);
        ticks(5);
        chk("lit_ring", int'(timer_state), 3);
        chk("lit_ring_time", dut_hhmmss(), 0);
        chk("lit_ring_sand", int'(sand_count), 0);
        ticks(5);
        chk("lit_ring_done", int'(timer_state), 0);
        chk("lit_piezo_off", int'(piezo_out), 0);

        // 20 s countdown continuing in clock mode
        do_clear();
        presses(B_S, 20);
        press(B_START);
        ticks(2);
        chk("lit_sand13", int'(sand_count), 13);
        chk("lit_green", int'(rgb_pwm[2] | rgb_pwm[0]), 0);
        timer_sw = 1'b0;
        ticks(18);
        chk("lit_bg_ring", int'(timer_state), 3);
        timer_sw = 1'b1;
        press(B_CONF);
        chk("lit_confirm", int'(timer_state), 0);

        // quick-add and increment wrap boundaries
        do_clear();
        press(B_A15); press(B_A10); press(B_A5);
        chk("lit_add30", dut_hhmmss(), 3000);
        do_clear();
        presses(B_M, 59);
        repeat (4) press(B_A15);
        chk("lit_add_carry", dut_hhmmss(), 15900);
        do_clear();
        presses(B_H, 99);
        presses(B_M, 59);
        chk("lit_max", dut_hhmmss(), 995900);
        press(B_A5);
        chk("lit_add_drop", dut_hhmmss(), 995900);
        press(B_M);
        chk("lit_m_wrap", dut_hhmmss(), 990000);
        press(B_A15);
        chk("lit_add_h99", dut_hhmmss(), 991500);
        press(B_H);
        chk("lit_h_wrap", dut_hhmmss(), 1500);

        // pause/resume, inc ignored while running, add while running, tick beats add
        do_clear();
        press(B_M);
        press(B_START);
        do_tick();
        chk("lit_59", dut_hhmmss(), 59);
        press(B_START);
        chk("lit_pause", int'(timer_state), 2);
        ticks(3);
        chk("lit_pause_hold", dut_hhmmss(), 59);
        press(B_START);
        chk("lit_resume", int'(timer_state), 1);
        press(B_S);
        chk("lit_inc_ignored", dut_hhmmss(), 59);
        do_tick();
        chk("lit_58", dut_hhmmss(), 58);
        press(B_A5);
        step(8);
        chk("lit_run_add", dut_hhmmss(), 558);
        chk("lit_sand14", int'(sand_count), 14);
        tick_1hz = 1'b1; btn[B_A10] = 1'b1; step(1);
        tick_1hz = 1'b0; btn[B_A10] = 1'b0; step(11);
        chk("lit_tick_beats_add", dut_hhmmss(), 557);

        // start at zero, clear while ringing, reset mid-count
        do_clear();
        press(B_START);
        chk("lit_start_zero", int'(timer_state), 0);
        presses(B_S, 2);
        press(B_START);
        ticks(2);
        chk("lit_ring2", int'(timer_state), 3);
        do_clear();
        chk_all_zero("lit_clear_ring");
        presses(B_S, 30);
        press(B_START);
        ticks(3);
        rst_n = 1'b0;
        #1;
        chk_all_zero("lit_async_rst");
        step(2);
        rst_n = 1'b1;
        step(2);
        chk_all_zero("lit_after_rst");

        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
